muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Sequencer that fronts a multiplier unit and a divider unit. It accepts one
// request at a time and issues it to the unit picked by the op code. It returns
// the selected half of the result through a valid/ready response port. It also
// supports flush/drain of in-flight work and a sticky busy-timeout error flag.
module muldiv_seq #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_sign,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,

  output logic        mul_in_valid,
  output logic [1:0]  mul_in_sign,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic        mul_out_valid,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,

  output logic        div_in_valid,
  input  logic        div_in_ready,
  output logic        div_signed,
  output logic [31:0] div_src1,
  output logic [31:0] div_src2,
  input  logic        div_out_valid,
  input  logic [31:0] quotient,
  input  logic [31:0] remainder,

  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,

  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_BUSY,
    S_DIV_BUSY,
    S_RESP,
    S_DRAIN
  } state_t;

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [3:0]    op_q;
  logic          sign_q;
  logic [31:0]   src1_q, src2_q;
  logic          issued_q, issued_d;   // issue handshake to the unit has completed
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   resp_data_q, resp_data_d;

  logic          accept;
  logic          op_div;
  logic          unit_out_valid;
  logic          unit_done;
  logic          timeout_hit;
  logic [31:0]   unit_result;

  // The lowest set op bit picks the unit: bit0/bit2 multiply, bit1/bit3 divide.
  function automatic logic op_is_div(input logic [3:0] op);
    return ~op[0] & (op[1] | (~op[2] & op[3]));
  endfunction

  assign req_ready    = (state_q == S_IDLE) & ~flush;
  assign accept       = req_valid & req_ready;
  assign op_div       = op_is_div(op_q);

  // A flush cancels an issue that has not handshaked yet, so unit valids are
  // gated by it and never show up in the cycle we abandon the request.
  assign mul_in_valid = (state_q == S_MUL_BUSY) & ~issued_q & ~flush;
  assign div_in_valid = (state_q == S_DIV_BUSY) & ~issued_q & ~flush;
  assign mul_in_sign  = {~sign_q, ~sign_q};
  assign mul_src1     = src1_q;
  assign mul_src2     = src2_q;
  assign div_signed   = sign_q;
  assign div_src1     = src1_q;
  assign div_src2     = src2_q;

  // Unit results are only meaningful once the issue handshake is done; earlier
  // pulses (including stale ones from an aborted operation) are ignored.
  assign unit_out_valid = op_div ? div_out_valid : mul_out_valid;
  assign unit_done      = issued_q & unit_out_valid;
  assign unit_result    = op_div ? (op_q[1] ? remainder : quotient)
                                 : (op_q[0] ? mul_lo    : mul_hi);
  assign timeout_hit    = (cnt_q == CNT_LAST);

  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;

  // Next-state, issue tracking, response capture and timeout decisions.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    issued_d    = issued_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          issued_d = 1'b0;
          if (req_op == 4'b0000) begin
            resp_data_d = '0;
            state_d     = S_RESP;
          end else if (op_is_div(req_op)) begin
            state_d = S_DIV_BUSY;
          end else begin
            state_d = S_MUL_BUSY;
          end
        end
      end

      S_MUL_BUSY, S_DIV_BUSY: begin
        if (flush) begin
          // A result arriving in the flush cycle is dropped; nothing is left to drain.
          state_d = (issued_q && !unit_out_valid) ? S_DRAIN : S_IDLE;
        end else if (unit_done) begin
          resp_data_d = unit_result;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (mul_in_valid || (div_in_valid && div_in_ready)) begin
          issued_d = 1'b1;
        end
      end

      S_RESP: begin
        if (flush || resp_ready) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (unit_done) begin
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Busy-cycle counter: restarts on every state change, runs only while busy.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == S_MUL_BUSY || state_q == S_DIV_BUSY || state_q == S_DRAIN)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (reset) begin
      state_q     <= S_IDLE;
      issued_q    <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      op_q        <= '0;
      sign_q      <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
      if (accept) begin
        op_q   <= req_op;
        sign_q <= req_sign;
        src1_q <= req_src1;
        src2_q <= req_src2;
      end
    end
  end

endmodule
